// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, ALU op encodings and EX control bundle
package id_ex_stage_reg_pkg;
  localparam int XLEN_D = 32;
  localparam int RA_W_D = 5;
  localparam int ALUOP_W_D = 4;
  localparam int CNT_W_D = 32;
  typedef enum logic [ALUOP_W_D-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_reg_hazard.sv
// hazard_detection_unit: flags a load in EX whose destination is read by the ID instruction
module hazard_detection_unit #(
  parameter int RA_W = 5
) (
  input  logic            valid_id,
  input  logic [RA_W-1:0] rs1_id,
  input  logic [RA_W-1:0] rs2_id,
  input  logic            use_rs1_id,
  input  logic            use_rs2_id,
  input  logic            valid_ex,
  input  logic            mem_read_ex,
  input  logic [RA_W-1:0] rd_ex,
  output logic            hazard
);
  logic w_rs1_hit, w_rs2_hit;
  assign w_rs1_hit = use_rs1_id & (rs1_id == rd_ex);
  assign w_rs2_hit = use_rs2_id & (rs2_id == rd_ex);
  assign hazard = valid_ex & mem_read_ex & (|rd_ex) & valid_id & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall, bubble/flush and stall counter
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RA_W = RA_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_id,
  input  logic [XLEN-1:0]    pc_id,
  input  logic [XLEN-1:0]    rs1_data_id,
  input  logic [XLEN-1:0]    rs2_data_id,
  input  logic [XLEN-1:0]    imm_id,
  input  logic [RA_W-1:0]    rs1_id,
  input  logic [RA_W-1:0]    rs2_id,
  input  logic [RA_W-1:0]    rd_id,
  input  logic               use_rs1_id,
  input  logic               use_rs2_id,
  input  logic               reg_write_id,
  input  logic               mem_read_id,
  input  logic               mem_write_id,
  input  logic               mem_to_reg_id,
  input  logic               alu_src_id,
  input  logic [ALUOP_W-1:0] alu_op_id,
  input  logic               flush_ex,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               valid_ex,
  output logic [XLEN-1:0]    pc_ex,
  output logic [XLEN-1:0]    rs1_data_ex,
  output logic [XLEN-1:0]    rs2_data_ex,
  output logic [XLEN-1:0]    imm_ex,
  output logic [RA_W-1:0]    rs1_ex,
  output logic [RA_W-1:0]    rs2_ex,
  output logic [RA_W-1:0]    rd_ex,
  output logic               reg_write_ex,
  output logic               mem_read_ex,
  output logic               mem_write_ex,
  output logic               mem_to_reg_ex,
  output logic               alu_src_ex,
  output logic [ALUOP_W-1:0] alu_op_ex,
  output logic [CNT_W-1:0]   stall_count
);
  logic               w_hazard, w_stall, w_bubble;
  ctrl_t              w_ctrl_id, r_ctrl;
  logic               r_valid;
  logic [XLEN-1:0]    r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [RA_W-1:0]    r_rs1, r_rs2, r_rd;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [CNT_W-1:0]   r_cnt;
  hazard_detection_unit #(.RA_W(RA_W)) u_hdu (
    .valid_id    (valid_id),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .use_rs1_id  (use_rs1_id),
    .use_rs2_id  (use_rs2_id),
    .valid_ex    (r_valid),
    .mem_read_ex (r_ctrl.mem_read),
    .rd_ex       (r_rd),
    .hazard      (w_hazard)
  );
  // a redirect discards the ID instruction, so it must not also stall the front end
  assign w_stall = w_hazard & ~flush_ex;
  assign w_bubble = flush_ex | w_stall;
  assign pc_write = ~w_stall;
  assign ifid_write = ~w_stall;
  assign w_ctrl_id = ctrl_t'({reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id} & {5{valid_id}});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl <= BUBBLE;
      r_pc <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd <= '0;
      r_alu_op <= '0;
      r_cnt <= '0;
    end else begin
      r_valid <= valid_id & ~w_bubble;
      r_ctrl <= w_bubble ? BUBBLE : w_ctrl_id;
      r_rs1 <= w_bubble ? '0 : rs1_id;
      r_rs2 <= w_bubble ? '0 : rs2_id;
      r_rd <= w_bubble ? '0 : rd_id;
      r_pc <= pc_id;
      r_rs1_data <= rs1_data_id;
      r_rs2_data <= rs2_data_id;
      r_imm <= imm_id;
      r_alu_op <= alu_op_id;
      if (w_stall && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign valid_ex = r_valid;
  assign pc_ex = r_pc;
  assign rs1_data_ex = r_rs1_data;
  assign rs2_data_ex = r_rs2_data;
  assign imm_ex = r_imm;
  assign rs1_ex = r_rs1;
  assign rs2_ex = r_rs2;
  assign rd_ex = r_rd;
  assign reg_write_ex = r_ctrl.reg_write;
  assign mem_read_ex = r_ctrl.mem_read;
  assign mem_write_ex = r_ctrl.mem_write;
  assign mem_to_reg_ex = r_ctrl.mem_to_reg;
  assign alu_src_ex = r_ctrl.alu_src;
  assign alu_op_ex = r_alu_op;
  assign stall_count = r_cnt;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed and random checks of id_ex_stage_reg against a behavioural model
module tb_id_ex_stage_reg;
  logic clk = 0, reset = 1;
  logic valid_id = 0, use_rs1_id = 0, use_rs2_id = 0, flush_ex = 0;
  logic [31:0] pc_id = 0, rs1_data_id = 0, rs2_data_id = 0, imm_id = 0;
  logic [4:0] rs1_id = 0, rs2_id = 0, rd_id = 0;
  logic reg_write_id = 0, mem_read_id = 0, mem_write_id = 0, mem_to_reg_id = 0, alu_src_id = 0;
  logic [3:0] alu_op_id = 0;
  logic pc_write, ifid_write, valid_ex, reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, alu_src_ex;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic [3:0] alu_op_ex, stall_count;
  int total = 0, bad = 0;
  typedef struct {
    bit v, rw, mr, mw, m2r, as, copied;
    bit [3:0] op;
    bit [4:0] rs1, rs2, rd;
    bit [31:0] pc, d1, d2, imm;
  } ex_t;
  ex_t m;
  int m_cnt;
  id_ex_stage_reg #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .reg_write_id(reg_write_id), .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
    .mem_to_reg_id(mem_to_reg_id), .alu_src_id(alu_src_id), .alu_op_id(alu_op_id),
    .flush_ex(flush_ex), .pc_write(pc_write), .ifid_write(ifid_write),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .alu_src_ex(alu_src_ex), .alu_op_ex(alu_op_ex),
    .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit m_hz();
    return m.v && m.mr && m.rd != 0 && valid_id &&
           ((use_rs1_id && rs1_id == m.rd) || (use_rs2_id && rs2_id == m.rd));
  endfunction
  task automatic instr(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                       input bit u2, input bit [4:0] rd, input bit mr, input bit rw);
    valid_id = v; rs1_id = rs1; use_rs1_id = u1; rs2_id = rs2; use_rs2_id = u2; rd_id = rd;
    mem_read_id = mr; reg_write_id = rw; mem_to_reg_id = mr; mem_write_id = 0;
    alu_src_id = mr; alu_op_id = 4'($urandom);
    pc_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom;
    flush_ex = 0;
  endtask
  task automatic step();
    bit st;
    #1;
    st = m_hz() && !flush_ex;
    chk("pc_write", pc_write, !st);
    chk("ifid_write", ifid_write, !st);
    @(posedge clk);
    if (flush_ex || st) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd = 0; m.rs1 = 0; m.rs2 = 0; m.copied = 0;
    end else begin
      m.v = valid_id; m.rw = reg_write_id & valid_id; m.mr = mem_read_id & valid_id;
      m.mw = mem_write_id & valid_id; m.m2r = mem_to_reg_id & valid_id; m.as = alu_src_id & valid_id;
      m.op = alu_op_id; m.rs1 = rs1_id; m.rs2 = rs2_id; m.rd = rd_id;
      m.pc = pc_id; m.d1 = rs1_data_id; m.d2 = rs2_data_id; m.imm = imm_id; m.copied = 1;
    end
    if (st && m_cnt < 15) m_cnt++;
    #1;
    chk("valid_ex", valid_ex, m.v);
    chk("reg_write_ex", reg_write_ex, m.rw);
    chk("mem_read_ex", mem_read_ex, m.mr);
    chk("mem_write_ex", mem_write_ex, m.mw);
    chk("rd_ex", rd_ex, m.rd);
    chk("rs1_ex", rs1_ex, m.rs1);
    chk("rs2_ex", rs2_ex, m.rs2);
    chk("stall_count", stall_count, m_cnt);
    if (m.copied) begin
      chk("pc_ex", pc_ex, m.pc);
      chk("rs1_data_ex", rs1_data_ex, m.d1);
      chk("rs2_data_ex", rs2_data_ex, m.d2);
      chk("imm_ex", imm_ex, m.imm);
      chk("mem_to_reg_ex", mem_to_reg_ex, m.m2r);
      chk("alu_src_ex", alu_src_ex, m.as);
      chk("alu_op_ex", alu_op_ex, m.op);
    end
  endtask
  task automatic do_reset();
    #2 reset = 1;
    #1;
    m = '{default: 0};
    m_cnt = 0;
    chk("rst_valid_ex", valid_ex, 0);
    chk("rst_rd_ex", rd_ex, 0);
    chk("rst_mem_read_ex", mem_read_ex, 0);
    chk("rst_reg_write_ex", reg_write_ex, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    #1 reset = 0;
  endtask
  initial begin
    int c0;
    m = '{default: 0};
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    instr(1, 1, 1, 2, 1, 9, 0, 1);
    step();
    chk("t1_pre_valid_ex", valid_ex, 1);
    do_reset();
    // load-use: lw x5 then add x6,x5,x7
    instr(1, 1, 1, 0, 0, 5, 1, 1);
    step();
    instr(1, 5, 1, 7, 1, 6, 0, 1);
    #1 chk("t2_pc_write", pc_write, 0);
    chk("t2_ifid_write", ifid_write, 0);
    step();
    chk("t2_bubble_valid", valid_ex, 0);
    chk("t2_bubble_rw", reg_write_ex, 0);
    step();
    chk("t2_rs1_ex", rs1_ex, 5);
    chk("t2_rd_ex", rd_ex, 6);
    chk("t2_stall_count", stall_count, 1);
    do_reset();
    instr(1, 1, 1, 0, 0, 0, 1, 1);
    step();
    instr(1, 0, 1, 0, 1, 8, 0, 1);
    #1 chk("t3_pc_write", pc_write, 1);
    step();
    chk("t3_valid_ex", valid_ex, 1);
    chk("t3_rd_ex", rd_ex, 8);
    instr(1, 1, 1, 0, 0, 5, 1, 1);
    step();
    instr(1, 3, 1, 5, 0, 4, 0, 1);
    #1 chk("t4_pc_write", pc_write, 1);
    step();
    chk("t4_valid_ex", valid_ex, 1);
    instr(1, 1, 1, 0, 0, 5, 1, 1);
    step();
    c0 = stall_count;
    instr(1, 5, 1, 0, 0, 6, 0, 1);
    flush_ex = 1;
    #1 chk("t5_pc_write", pc_write, 1);
    step();
    chk("t5_valid_ex", valid_ex, 0);
    chk("t5_rd_ex", rd_ex, 0);
    chk("t5_stall_count", stall_count, c0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      instr(1, 1, 1, 0, 0, 5, 1, 1);
      step();
      instr(1, 2, 1, 5, 1, 6, 0, 0);
      step();
    end
    chk("t6_saturated", stall_count, 4'hF);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      instr($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, 1'($urandom));
      mem_write_id = ($urandom_range(0, 3) == 0);
      flush_ex = ($urandom_range(0, 9) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
